// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered one-hot decoder with prescaled up/down auto-scan
module scan_decoder #(
    parameter int SEL_W = 2,
    parameter int DIV_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      x,
    input  logic                  load,
    input  logic [DIV_W-1:0]      div,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  tick,
    output logic                  wrap
);

    localparam int N = 2 ** SEL_W;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};
    localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     y_q, y_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    mode_e            mode_s;

    assign mode_s = mode_e'(mode);

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        y_d    = '0;
        if (en) begin
            case (mode_s)
                MODE_DIRECT: begin
                    idx_d = x;
                    cnt_d = '0;
                end
                MODE_UP, MODE_DOWN: begin
                    // load beats terminal count; >= also catches div lowered mid-count
                    if (load) begin
                        idx_d = x;
                        cnt_d = '0;
                    end else if (cnt_q >= div) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        if (mode_s == MODE_UP) begin
                            idx_d  = idx_q + 1'b1;
                            wrap_d = (idx_q == IDX_MAX);
                        end else begin
                            idx_d  = idx_q - 1'b1;
                            wrap_d = (idx_q == '0);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
            y_d = ONE_N << idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            y_q    <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - directed and random checks of scan_decoder at SEL_W=2 and SEL_W=3
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [2:0]  x;
    logic        load;
    logic [15:0] div;
    logic [3:0]  y2;
    logic [1:0]  idx2;
    logic        tick2, wrap2;
    logic [7:0]  y3;
    logic [2:0]  idx3;
    logic        tick3, wrap3;

    int n_cmp = 0;
    int n_err = 0;

    int m_idx[2], m_cnt[2], m_y[2], m_tick[2], m_wrap[2];
    int saved;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(2), .DIV_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x[1:0]), .load(load),
        .div(div), .y(y2), .idx(idx2), .tick(tick2), .wrap(wrap2)
    );

    scan_decoder #(.SEL_W(3), .DIV_W(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x), .load(load),
        .div(div), .y(y3), .idx(idx3), .tick(tick3), .wrap(wrap3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_y[k] = 0; m_tick[k] = 0; m_wrap[k] = 0;
        end
    endtask

    // Behavioural reference: index is an integer modulo n, prescaler an integer counter
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int n;
            int old;
            n = (k == 0) ? 4 : 8;
            old = m_idx[k];
            m_tick[k] = 0;
            m_wrap[k] = 0;
            if (!en) begin
                m_y[k] = 0;
            end else begin
                if (mode == 2'b00) begin
                    m_idx[k] = int'(x) % n;
                    m_cnt[k] = 0;
                end else if (mode != 2'b11) begin
                    if (load) begin
                        m_idx[k] = int'(x) % n;
                        m_cnt[k] = 0;
                    end else if (m_cnt[k] >= int'(div)) begin
                        m_cnt[k] = 0;
                        m_tick[k] = 1;
                        if (mode == 2'b01) begin
                            m_idx[k] = (old + 1) % n;
                            m_wrap[k] = (old == n - 1) ? 1 : 0;
                        end else begin
                            m_idx[k] = (old + n - 1) % n;
                            m_wrap[k] = (old == 0) ? 1 : 0;
                        end
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                m_y[k] = 1 << m_idx[k];
            end
        end
    endtask

    task automatic check_all();
        chk("y2", 32'(y2), m_y[0]);
        chk("idx2", 32'(idx2), m_idx[0]);
        chk("tick2", 32'(tick2), m_tick[0]);
        chk("wrap2", 32'(wrap2), m_wrap[0]);
        chk("y3", 32'(y3), m_y[1]);
        chk("idx3", 32'(idx3), m_idx[1]);
        chk("tick3", 32'(tick3), m_tick[1]);
        chk("wrap3", 32'(wrap3), m_wrap[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int seq_up[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 2'b00; x = '0; load = 1'b0; div = '0;
        #1;
        model_reset();
        check_all();
        chk("rst_y2", 32'(y2), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Direct decode x=0..3, then enable drop
        for (int i = 0; i < 4; i++) begin
            x = 3'(i);
            step();
            chk("dir_y2", 32'(y2), 32'(1) << i);
        end
        en = 1'b0;
        step();
        chk("dis_y2", 32'(y2), 0);
        en = 1'b1;

        // Scan up, div=2, from reset
        mode = 2'b01; div = 16'd2;
        do_reset();
        chk("up_idx0", 32'(idx2), seq_up[0]);
        for (int i = 1; i < 13; i++) begin
            step();
            chk("up_idx", 32'(idx2), seq_up[i]);
            chk("up_tick", 32'(tick2), (seq_up[i] != seq_up[i-1]) ? 1 : 0);
            chk("up_wrap", 32'(wrap2), (seq_up[i-1] == 3 && seq_up[i] == 0) ? 1 : 0);
        end

        // Scan down with wrap on the 3-bit instance, div=0
        mode = 2'b10; div = '0; load = 1'b1; x = 3'd1;
        step();
        chk("dn_load", 32'(idx3), 1);
        load = 1'b0;
        step();
        chk("dn_idx_a", 32'(idx3), 0);
        chk("dn_tick_a", 32'(tick3), 1);
        chk("dn_wrap_a", 32'(wrap3), 0);
        step();
        chk("dn_idx_b", 32'(idx3), 7);
        chk("dn_wrap_b", 32'(wrap3), 1);
        chk("dn_y_b", 32'(y3), 32'h80);
        step();
        chk("dn_idx_c", 32'(idx3), 6);
        chk("dn_wrap_c", 32'(wrap3), 0);
        chk("dn_y_c", 32'(y3), 32'h40);

        // Load coincident with terminal count
        mode = 2'b01; div = 16'd1; load = 1'b1; x = 3'd0;
        step();
        load = 1'b0;
        step();
        load = 1'b1; x = 3'd2;
        step();
        chk("lt_idx", 32'(idx2), 2);
        chk("lt_tick", 32'(tick2), 0);
        load = 1'b0;
        step();
        chk("lt_tick1", 32'(tick2), 0);
        step();
        chk("lt_tick2", 32'(tick2), 1);
        chk("lt_idx2", 32'(idx2), 3);

        // Hold and enable freeze with preserved prescale phase
        div = 16'd3; load = 1'b1; x = 3'd1;
        step();
        load = 1'b0;
        step();
        step();
        saved = int'(idx2);
        mode = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_idx", 32'(idx2), saved);
            chk("hold_y", 32'(y2), 32'(1) << saved);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_idx", 32'(idx2), saved);
            chk("frz_y", 32'(y2), 0);
        end
        mode = 2'b01; en = 1'b1;
        step();
        chk("res_tick0", 32'(tick2), 0);
        step();
        chk("res_tick1", 32'(tick2), 1);
        chk("res_idx", 32'(idx2), (saved + 1) % 4);

        // Asynchronous reset between edges mid-scan
        div = 16'd2;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("ar_y3", 32'(y3), 0);
        #1;
        rst_n = 1'b1;
        step();
        chk("ar_t1", 32'(tick2), 0);
        step();
        chk("ar_t2", 32'(tick2), 0);
        step();
        chk("ar_t3", 32'(tick2), 1);

        // Random stimulus against the reference model
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            x    = 3'($urandom);
            load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) div = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                #1;
                rst_n = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered one-hot decoder: a SEL_W-bit index drives a 2^SEL_W-bit one-hot output gated by an enable. Beyond direct decoding, it can auto-scan the index up or down at a programmable prescaled rate, load a start index, and hold. It sits between control logic and multiplexed outputs such as seven-segment digit selects and LED column drivers in the lab designs.

## Interface
- SEL_W, default 2: index width; output width is 2^SEL_W.
- DIV_W, default 16: prescaler width.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  output enable; also gates all state advance
- mode  input  2  00 direct, 01 scan up, 10 scan down, 11 hold
- x  input  SEL_W  direct index / load value
- load  input  1  scan-mode load of x into index
- div  input  DIV_W  prescale period minus one (advance every div+1 cycles)
- y  output  2^SEL_W  registered one-hot output, all-zero when disabled
- idx  output  SEL_W  current registered index
- tick  output  1  one-cycle pulse, high in the cycle idx has just advanced
- wrap  output  1  one-cycle pulse, high with tick when the advance wrapped

## Operation
- State: idx register, prescaler cnt (DIV_W bits), and registered y, tick and wrap.
- Reset (rst_n low, any time, asynchronous): idx=0, cnt=0, y=0, tick=0, wrap=0. This aborts any scan in progress.
- Priority per cycle: en=0, then mode, then (in scan modes) load, then advance.
- en=0: idx and cnt are frozen; y<=0, tick<=0, wrap<=0.
- en=1, the next output is always y<=onehot(idx_next), i.e. bit idx_next set and all others 0.
- Direct (00):
  - idx<=x and cnt<=0.
  - tick and wrap are 0.
- Scan up (01) / scan down (10):
  - If load=1: idx<=x, cnt<=0, tick=0, wrap=0. Load takes precedence over a coincident terminal count.
  - Otherwise, if cnt>=div (terminal; the >= also covers div lowered mid-count): cnt<=0, idx<=idx±1 modulo 2^SEL_W, and tick<=1.
    - wrap<=1 when scan up goes from 2^SEL_W-1 to 0.
    - wrap<=1 when scan down goes from 0 to 2^SEL_W-1.
  - Otherwise: cnt<=cnt+1, idx is unchanged, tick=0.
  - div=0 advances idx every enabled cycle.
- Hold (11):
  - idx and cnt are frozen.
  - y stays onehot(idx) while en=1.
  - tick and wrap are 0.
- Mode change between up and down keeps cnt, so the prescale phase continues.
- Entering hold or leaving hold keeps cnt.
- Entering direct clears cnt.
- Index arithmetic is unsigned SEL_W-bit with natural wrap. The prescaler compare is unsigned DIV_W-bit.

## Timing
- All outputs are registered. y, idx, tick and wrap update on the same clock edge and are mutually consistent.
- Direct-mode latency: x sampled at edge k appears on idx and y after edge k.
- Enable latency: en falling at edge k gives y=0 after edge k. en rising gives y=onehot(idx) after the next edge.
- Scan period: with constant div=D, successive tick pulses are exactly D+1 cycles apart, counted from the first cycle after a load, a direct-to-scan switch, or a reset release.
- Load in scan mode: idx=x after the edge. The next advance occurs D+1 cycles later.
- tick and wrap are never high for more than one consecutive cycle unless div=0. With div=0, tick stays high every cycle in scan modes.
- Reset asserted mid-cycle clears the outputs immediately, without waiting for clk.

## Test plan
- Reset and direct decode: SEL_W=2, en=1, mode=00, x=0..3 over four cycles.
  - y must read 0001, 0010, 0100, 1000, each one cycle after the x value.
  - With en=0, y=0000 on the next cycle.
- Scan up with prescale: div=2, mode=01, from reset.
  - idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 over 13 cycles.
  - tick is high on each change; wrap is high only on 3 to 0.
- Scan down with wrap: SEL_W=3, div=0, load x=1 then mode=10.
  - idx sequence 1,0,7,6.
  - tick every cycle; wrap only with idx=7; y=0x80 then 0x40.
- Load versus terminal: div=1, scan up, load=1 with x=2 in a terminal-count cycle.
  - idx=2 with tick=0.
  - The next tick comes 2 cycles later, with idx=3.
- Hold and enable freeze: scan up div=3, switch to mode=11 for 5 cycles, then drop en=0 for 3 cycles, then return to mode=01 with en=1.
  - idx is frozen throughout; y=0 only while en=0.
  - The advance resumes at the preserved cnt phase.
- Async reset mid-scan: pulse rst_n low between clock edges during scan.
  - y, idx, tick and wrap clear immediately.
  - After release, the first tick comes div+1 cycles later.
